mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator-side front end for the unified word memory (combinational read, posedge write, indexed directly by Address).
- Accepts single-beat load/store requests from the CPU datapath over a valid/ready handshake.
- Drives the memory's Address, writeData and writeEnable pins and returns read data on a registered response channel.
- Performs read-modify-write for byte-masked stores and rejects out-of-range addresses without touching memory.

Parameters:
- ADDR_W, 32, width of request and memory address.
- DATA_W, 32, data word width; must equal 4 x 8.
- DEPTH, 4096, number of memory words; valid addresses are 0..DEPTH-1.

Ports:
- clk  input  1  rising-edge clock shared with the memory.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  word index.
- req_wdata  input  DATA_W  store data.
- req_be  input  4  byte enables for stores; bit i covers bits 8i+7:8i; ignored for loads.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  DATA_W  load data; 0 for stores and errors.
- resp_err  output  1  address out of range.
- mem_addr  output  ADDR_W  to memory Address.
- mem_wdata  output  DATA_W  to memory writeData.
- mem_we  output  1  to memory writeEnable.
- mem_rdata  input  DATA_W  from memory MemData, combinational in mem_addr.

Behaviour:
- States: IDLE, READ, WRITE, RMW_RD, RMW_WR, RESP; 3-bit state register, async reset to IDLE.
- Reset values, applied immediately on rst_n low: addr_q=0, wdata_q=0, be_q=0, we_q=0, rdata_q=0, err_q=0.
- Output values following from reset: mem_addr=0, mem_wdata=0, mem_we=0, resp_valid=0, resp_rdata=0, resp_err=0.
- req_ready = (state==IDLE) and rst_n.
- No combinational path from req_* to mem_*. mem_addr=addr_q, mem_wdata=wdata_q, mem_we=(state==WRITE or state==RMW_WR).
- IDLE: on req_valid, latch addr, wdata, be and we, then branch:
  - addr >= DEPTH -> RESP with err_q=1, rdata_q=0; no memory access.
  - load -> READ.
  - store with be=4'hF -> WRITE.
  - store with be=0 -> RESP, no access.
  - store with any other be -> RMW_RD.
- READ: one cycle; rdata_q <= mem_rdata; -> RESP.
- WRITE: one cycle with mem_we=1; memory commits wdata_q at the end of this cycle; -> RESP.
- RMW_RD: one cycle; wdata_q <= merge, where each enabled byte takes wdata_q and each disabled byte takes mem_rdata; -> RMW_WR.
- RMW_WR: one cycle with mem_we=1 writing the merged word; -> RESP.
- RESP: resp_valid=1; resp_rdata=rdata_q; resp_err=err_q. Hold all response outputs stable until resp_ready. On resp_ready -> IDLE and clear rdata_q and err_q. A new request is not accepted in the same cycle as the response handshake.
- Latency from the accept edge to resp_valid (resp_ready held high):
  - read: 2 cycles.
  - full write: 2 cycles.
  - masked write: 3 cycles.
  - error or be=0: 1 cycle.
- Throughput: at most one outstanding request.
- Reset mid-operation: state returns to IDLE and mem_we drops immediately; a store aborted before its write cycle completes leaves memory unchanged; no response is issued.
- Address exactly DEPTH-1 is valid; DEPTH is an error. The upper address bits are compared in full, with no wrap-around.

Test Plan:
- Memory word 2 = 20; load addr 2 with resp_ready=1 -> resp_valid two cycles after accept, resp_rdata=32'd20, resp_err=0, mem_we never asserted.
- Full store addr 6, wdata 0xDEADBEEF, be=4'hF -> mem_we high exactly one cycle with mem_addr=6; a following load of 6 returns 0xDEADBEEF.
- Word 3 = 0x00000003; store addr 3, wdata 0xAABBCCDD, be=4'b0101 -> exactly one mem_we pulse with mem_wdata=0x00BB00DD; a load of 3 returns 0x00BB00DD.
- Load addr 4096 -> resp_err=1, resp_rdata=0 one cycle after accept; mem_we=0; mem_addr is never driven with 4096 during a write. Load addr 4095 -> resp_err=0.
- Hold resp_ready=0 for 5 cycles after a load of addr 1 -> resp_valid and resp_rdata=1 stable throughout, req_ready=0; resp_ready=1 -> IDLE next cycle, req_ready=1.
- Assert rst_n=0 during RMW_RD of a masked store to addr 5 (value 5) -> mem_we stays 0, outputs return to reset values asynchronously; after release, a load of addr 5 returns 5.

Source files
------------

// File: rtl/mem_access_unit.sv
// Front end between CPU load/store requests and the unified word memory.
// One request in flight; byte-masked stores are done as read-merge-write.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WRITE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    // Extra top bit keeps the range check exact for any DEPTH, with no wrap.
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_be;
    logic              r_we;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              w_oob;
    logic [DATA_W-1:0] w_merge;

    assign w_oob = ({1'b0, req_addr} >= LP_DEPTH);

    always_comb begin
        w_merge = mem_rdata;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_be[i]) w_merge[8*i +: 8] = r_wdata[8*i +: 8];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_oob)                 w_next = S_RESP;
                    else if (!req_we)          w_next = S_READ;
                    else if (req_be == 4'hF)   w_next = S_WRITE;
                    else if (req_be == 4'h0)   w_next = S_RESP;
                    else                       w_next = S_RMW_RD;
                end
            end
            S_READ:   w_next = S_RESP;
            S_WRITE:  w_next = S_RESP;
            S_RMW_RD: w_next = S_RMW_WR;
            S_RMW_WR: w_next = S_RESP;
            S_RESP:   if (resp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        r_we    <= req_we;
                        r_rdata <= '0;
                        r_err   <= w_oob;
                    end
                end
                S_READ:   r_rdata <= mem_rdata;
                S_RMW_RD: r_wdata <= w_merge;
                S_RESP: begin
                    if (resp_ready) begin
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE) && rst_n;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_we     = ((r_state == S_WRITE) || (r_state == S_RMW_WR)) && r_we;

endmodule
